mode_guard: RTL and testbench



---
 rtl/mode_guard.sv | 165 ++++++++++++++++
 tb/tb_mode_guard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mode_guard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mode_guard                                                   |
// | Description : Debounces and sanitises a direction request, inserts H-bridge|
// |               dead-time between actuator classes, and applies a refresh    |
// |               watchdog before driving the 4-bit motor mode bus.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mode_guard #(
    parameter int unsigned STABLE_CYC  = 1_000_000,
    parameter int unsigned DEAD_CYC    = 2_500_000,
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned CW          = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_mode,
    input  logic       req_valid,
    output logic [3:0] mode,
    output logic       dead,
    output logic       stale
);

    localparam logic [3:0]    c_NONE      = 4'b0000;
    localparam logic [CW-1:0] c_ONE       = CW'(1);
    localparam logic [CW-1:0] c_STAB_LAST = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] c_DEAD_LAST = CW'(DEAD_CYC - 1);
    localparam logic [CW-1:0] c_WD_LAST   = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] c_WD_SAT    = CW'(TIMEOUT_CYC);

    localparam logic [2:0] c_CLS_IDLE = 3'd0;
    localparam logic [2:0] c_CLS_RF   = 3'd1;
    localparam logic [2:0] c_CLS_RR   = 3'd2;
    localparam logic [2:0] c_CLS_LF   = 3'd3;
    localparam logic [2:0] c_CLS_LR   = 3'd4;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_DRIVE = 2'd1;
    localparam logic [1:0] c_S_DEAD  = 2'd2;
    localparam logic [1:0] c_S_STALE = 2'd3;

    // Illegal codes fall into the idle class, which doubles as the sanitiser.
    function automatic logic [2:0] f_class(input logic [3:0] code);
        case (code)
            4'b0010:                   f_class = c_CLS_RF;
            4'b1000:                   f_class = c_CLS_RR;
            4'b0001, 4'b0011, 4'b0101: f_class = c_CLS_LF;
            4'b0100, 4'b0110, 4'b0111: f_class = c_CLS_LR;
            default:                   f_class = c_CLS_IDLE;
        endcase
    endfunction

    logic [3:0]    w_san;
    logic [3:0]    r_cand;
    logic [3:0]    r_acc;
    logic [CW-1:0] r_stab_cnt;
    logic [CW-1:0] r_wd_cnt;
    logic          w_trip;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_mode;
    logic [3:0]    w_mode_nxt;
    logic [CW-1:0] r_dead_cnt;
    logic [CW-1:0] w_dead_cnt_nxt;

    assign w_san = (f_class(req_mode) != c_CLS_IDLE) ? req_mode : c_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand     <= c_NONE;
            r_acc      <= c_NONE;
            r_stab_cnt <= '0;
        end else if (w_san != r_cand) begin
            r_cand     <= w_san;
            r_stab_cnt <= '0;
        end else if (r_stab_cnt == c_STAB_LAST) begin
            r_acc      <= r_cand;
        end else begin
            r_stab_cnt <= r_stab_cnt + c_ONE;
        end
    end

    // Saturating at TIMEOUT_CYC keeps a long silence from re-tripping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (req_valid) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != c_WD_SAT) begin
            r_wd_cnt <= r_wd_cnt + c_ONE;
        end
    end

    assign w_trip = !req_valid && (r_wd_cnt == c_WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_S_IDLE;
            r_mode     <= c_NONE;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_dead_cnt <= w_dead_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_dead_cnt_nxt = r_dead_cnt;
        if (w_trip) begin
            w_state_nxt = c_S_STALE;
            w_mode_nxt  = c_NONE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    w_mode_nxt = c_NONE;
                    if (r_acc != c_NONE) begin
                        w_state_nxt = c_S_DRIVE;
                        w_mode_nxt  = r_acc;
                    end
                end
                c_S_DRIVE: begin
                    if (r_acc == c_NONE) begin
                        w_state_nxt = c_S_IDLE;
                        w_mode_nxt  = c_NONE;
                    end else if (f_class(r_acc) != f_class(r_mode)) begin
                        w_state_nxt    = c_S_DEAD;
                        w_mode_nxt     = c_NONE;
                        w_dead_cnt_nxt = '0;
                    end else begin
                        w_mode_nxt = r_acc;
                    end
                end
                c_S_DEAD: begin
                    w_mode_nxt = c_NONE;
                    // The exit target follows acc, but the gap always runs full length.
                    if (r_dead_cnt == c_DEAD_LAST) begin
                        w_mode_nxt  = r_acc;
                        w_state_nxt = (r_acc == c_NONE) ? c_S_IDLE : c_S_DRIVE;
                    end else begin
                        w_dead_cnt_nxt = r_dead_cnt + c_ONE;
                    end
                end
                c_S_STALE: begin
                    w_mode_nxt = c_NONE;
                    if (req_valid && (r_acc == c_NONE)) begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                    w_mode_nxt  = c_NONE;
                end
            endcase
        end
    end

    assign mode  = r_mode;
    assign dead  = (r_state == c_S_DEAD);
    assign stale = (r_state == c_S_STALE);

endmodule
`default_nettype wire

// File: tb/tb_mode_guard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mode_guard                                                |
// | Description : Directed and random stimulus against a behavioural model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mode_guard;

    localparam int STABLE  = 4;
    localparam int DEAD    = 8;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_mode;
    logic       req_valid;
    logic [3:0] mode;
    logic       dead;
    logic       stale;

    always #5 clk = ~clk;

    mode_guard #(
        .STABLE_CYC (STABLE),
        .DEAD_CYC   (DEAD),
        .TIMEOUT_CYC(TIMEOUT),
        .CW         (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_mode (req_mode),
        .req_valid(req_valid),
        .mode     (mode),
        .dead     (dead),
        .stale    (stale)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [3:0] legal_codes [9] = '{4'b0000, 4'b0010, 4'b1000, 4'b0001, 4'b0100,
                                    4'b0011, 4'b0101, 4'b0110, 4'b0111};

    // Reference model: acc from the recent input history, mode from class rules.
    logic [3:0] m_acc;
    logic [3:0] m_mode;
    int         m_dead_left;
    bit         m_stale;
    int         m_quiet;
    logic [3:0] hist [$];

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic bit is_legal(input logic [3:0] c);
        foreach (legal_codes[i]) if (legal_codes[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int class_of(input logic [3:0] c);
        if (c == 4'b0010) return 1;
        if (c == 4'b1000) return 2;
        if (c inside {4'b0001, 4'b0011, 4'b0101}) return 3;
        if (c inside {4'b0100, 4'b0110, 4'b0111}) return 4;
        return 0;
    endfunction

    task automatic model_reset();
        m_acc       = 4'b0000;
        m_mode      = 4'b0000;
        m_dead_left = 0;
        m_stale     = 1'b0;
        m_quiet     = 0;
        hist.delete();
        repeat (STABLE + 1) hist.push_back(4'b0000);
    endtask

    // One rising edge with the given inputs.
    task automatic model_step(input logic [3:0] r, input bit v);
        logic [3:0] san;
        int         q_new;
        bit         same;
        san   = is_legal(r) ? r : 4'b0000;
        q_new = v ? 0 : m_quiet + 1;
        if (q_new == TIMEOUT) begin
            m_stale     = 1'b1;
            m_mode      = 4'b0000;
            m_dead_left = 0;
        end else if (m_stale) begin
            if (v && m_acc == 4'b0000) m_stale = 1'b0;
        end else if (m_dead_left > 0) begin
            m_dead_left--;
            if (m_dead_left == 0) m_mode = m_acc;
        end else if (m_mode == 4'b0000) begin
            m_mode = m_acc;
        end else if (class_of(m_acc) == class_of(m_mode)) begin
            m_mode = m_acc;
        end else begin
            m_mode = 4'b0000;
            if (m_acc != 4'b0000) m_dead_left = DEAD;
        end
        m_quiet = q_new;
        hist.push_back(san);
        void'(hist.pop_front());
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != san) same = 1'b0;
        if (same) m_acc = san;
    endtask

    task automatic compare_outputs();
        check("mode",  mode,          m_mode);
        check("dead",  {3'b000, dead},  {3'b000, (m_dead_left > 0)});
        check("stale", {3'b000, stale}, {3'b000, m_stale});
    endtask

    task automatic step(input logic [3:0] r, input bit v);
        @(negedge clk);
        compare_outputs();
        req_mode  = r;
        req_valid = v;
        model_step(r, v);
        cyc++;
    endtask

    task automatic hold(input logic [3:0] r, input int n, input bit pulse);
        for (int i = 0; i < n; i++) step(r, pulse && (cyc % 10 == 0));
    endtask

    task automatic async_reset();
        @(negedge clk);
        compare_outputs();
        #2 rst_n = 1'b0;
        #1;
        check("arst_mode",  mode,            4'b0000);
        check("arst_dead",  {3'b000, dead},  4'b0000);
        check("arst_stale", {3'b000, stale}, 4'b0000);
        model_reset();
        @(negedge clk);
        compare_outputs();
        rst_n     = 1'b1;
        req_mode  = 4'b0000;
        req_valid = 1'b1;
        model_step(4'b0000, 1'b1);
        cyc++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_mode  = 4'b0000;
        req_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_outputs();
        rst_n     = 1'b1;
        req_valid = 1'b1;
        model_step(4'b0000, 1'b1);
        cyc++;

        // Debounce: long hold vs short pulse.
        hold(4'b0010, 10, 1'b1);
        hold(4'b0000, 10, 1'b1);
        hold(4'b0010, 3,  1'b1);
        hold(4'b0000, 10, 1'b1);
        // Illegal code.
        hold(4'b1111, 20, 1'b1);
        // Same-class change, no dead-time.
        hold(4'b0001, 12, 1'b1);
        hold(4'b0011, 12, 1'b1);
        hold(4'b0000, 12, 1'b1);
        // Reversal and cross-class changes.
        hold(4'b0010, 12, 1'b1);
        hold(4'b1000, 20, 1'b1);
        hold(4'b0010, 20, 1'b1);
        hold(4'b0001, 20, 1'b1);
        // Retarget back to the original class during dead-time.
        hold(4'b0100, 7,  1'b1);
        hold(4'b0001, 20, 1'b1);
        // Watchdog trip, STALE hold, and recovery.
        hold(4'b0100, 12, 1'b1);
        hold(4'b0100, 70, 1'b0);
        step(4'b0100, 1'b1);
        hold(4'b0000, 6,  1'b0);
        step(4'b0000, 1'b1);
        hold(4'b0100, 12, 1'b1);
        // Coincident refresh on the would-be trip cycle.
        hold(4'b0100, TIMEOUT - 1, 1'b0);
        step(4'b0100, 1'b1);
        hold(4'b0100, 5, 1'b1);
        // Asynchronous reset mid dead-time.
        hold(4'b0000, 12, 1'b1);
        hold(4'b0010, 12, 1'b1);
        hold(4'b1000, 8,  1'b1);
        async_reset();
        hold(4'b0110, 12, 1'b1);

        // Random phase.
        for (int s = 0; s < 200; s++) begin
            logic [3:0] code;
            int         len;
            bit         quiet;
            code  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 8)];
            quiet = ($urandom_range(0, 9) == 0);
            len   = quiet ? $urandom_range(40, 90) : $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                step(code, !quiet && ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
